// File: rtl/id_stall_sequencer_pkg.sv
// Shared definitions for the ID-stage stall sequencer: FSM states and stall lengths.
package id_stall_sequencer_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam int unsigned STALL_NONE  = 0;
  localparam int unsigned STALL_LU    = 1;
  localparam int unsigned STALL_BR_LD = 2;

endpackage

// File: rtl/id_stall_sequencer_hazard_match.sv
// Source-operand vs. EX/MEM destination compare; register 0 never matches.
module hazard_match (
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       useRs,
  input  logic       useRt,
  input  logic [4:0] exRd,
  input  logic [4:0] memRd,
  output logic       depEx,
  output logic       depMem
);

  always_comb begin
    depEx  = (exRd != 5'd0) &&
             ((useRs && (rs == exRd)) || (useRt && (rt == exRd)));
    depMem = (memRd != 5'd0) &&
             ((useRs && (rs == memRd)) || (useRt && (rt == memRd)));
  end

endmodule

// File: rtl/id_stall_sequencer.sv
// Counted stall / bubble / flush sequencer for the IF/ID/EX boundary around ID.
module id_stall_sequencer
  import id_stall_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             ID_branch,
  input  logic             ID_redirect,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_rd,
  input  logic             EXMEM_MemRead,
  input  logic [4:0]       EXMEM_rd,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             ControlMuxsignal,
  output logic             IFIDFlush,
  output logic             stall_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned REM_W = $clog2(MAX_STALL + 1);

  logic             depEx;
  logic             depMem;
  state_t           state;
  state_t           stateNext;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] remNext;
  logic [REM_W-1:0] need;
  logic [CNT_W-1:0] cnt;

  hazard_match uMatch (
    .rs    (ID_rs),
    .rt    (ID_rt),
    .useRs (ID_use_rs),
    .useRt (ID_use_rt),
    .exRd  (IDEX_rd),
    .memRd (EXMEM_rd),
    .depEx (depEx),
    .depMem(depMem)
  );

  always_comb begin
    need = REM_W'(STALL_NONE);
    if (ID_branch && IDEX_MemRead && depEx)
      need = REM_W'(STALL_BR_LD);
    else if (IDEX_MemRead && depEx)
      need = REM_W'(STALL_LU);
    else if (ID_branch && IDEX_RegWrite && depEx)
      need = REM_W'(STALL_LU);
    else if (ID_branch && EXMEM_MemRead && depMem)
      need = REM_W'(STALL_LU);
  end

  // The RUN cycle that detects the hazard is the first bubble; STALL holds
  // the remaining need-1 bubbles, so rem counts bubbles still owed in STALL.
  always_comb begin
    stateNext        = state;
    remNext          = rem;
    PCWrite          = 1'b1;
    IFIDWrite        = 1'b1;
    ControlMuxsignal = 1'b0;
    IFIDFlush        = 1'b0;
    if (!Reset) begin
      unique case (state)
        ST_RUN: begin
          if (need != '0) begin
            PCWrite          = 1'b0;
            IFIDWrite        = 1'b0;
            ControlMuxsignal = 1'b1;
            if (need > REM_W'(1)) begin
              stateNext = ST_STALL;
              remNext   = need - REM_W'(1);
            end
          end else if (ID_redirect) begin
            IFIDFlush = 1'b1;
          end
        end
        ST_STALL: begin
          PCWrite          = 1'b0;
          IFIDWrite        = 1'b0;
          ControlMuxsignal = 1'b1;
          remNext          = rem - REM_W'(1);
          if (rem <= REM_W'(1)) begin
            stateNext = ST_RUN;
            remNext   = '0;
          end
        end
        default: begin
          stateNext = ST_RUN;
          remNext   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_RUN;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      rem   <= remNext;
      if (ControlMuxsignal && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign stall_busy   = (state == ST_STALL);
  assign stall_cycles = cnt;

endmodule

// File: tb/tb_id_stall_sequencer.sv
// Directed bench for id_stall_sequencer; a 2-bit-counter copy exercises saturation.
module tb_id_stall_sequencer;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ID_rs, ID_rt, IDEX_rd, EXMEM_rd;
  logic        ID_use_rs, ID_use_rt, ID_branch, ID_redirect;
  logic        IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead;
  logic        PCWrite, IFIDWrite, ControlMuxsignal, IFIDFlush, stall_busy;
  logic [15:0] stall_cycles;
  logic        sPCWrite, sIFIDWrite, sControlMuxsignal, sIFIDFlush, sStallBusy;
  logic [1:0]  sStallCycles;

  int unsigned nAsserts = 0;
  int unsigned nFails   = 0;

  id_stall_sequencer #(.CNT_W(16), .MAX_STALL(2)) dut (
    .Clk(Clk), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_branch(ID_branch),
    .ID_redirect(ID_redirect), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_rd(IDEX_rd),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_rd(EXMEM_rd),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .ControlMuxsignal(ControlMuxsignal), .IFIDFlush(IFIDFlush),
    .stall_busy(stall_busy), .stall_cycles(stall_cycles)
  );

  id_stall_sequencer #(.CNT_W(2), .MAX_STALL(2)) dutSat (
    .Clk(Clk), .Reset(Reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_branch(ID_branch),
    .ID_redirect(ID_redirect), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_rd(IDEX_rd),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_rd(EXMEM_rd),
    .PCWrite(sPCWrite), .IFIDWrite(sIFIDWrite),
    .ControlMuxsignal(sControlMuxsignal), .IFIDFlush(sIFIDFlush),
    .stall_busy(sStallBusy), .stall_cycles(sStallCycles)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the four combinational controls plus the registered busy flag.
  task automatic chkOut(input string tag, input logic pcw, input logic ifw,
                        input logic bub, input logic fl, input logic busy);
    chk({tag, ".PCWrite"},          32'(PCWrite),          32'(pcw));
    chk({tag, ".IFIDWrite"},        32'(IFIDWrite),        32'(ifw));
    chk({tag, ".ControlMuxsignal"}, 32'(ControlMuxsignal), 32'(bub));
    chk({tag, ".IFIDFlush"},        32'(IFIDFlush),        32'(fl));
    chk({tag, ".stall_busy"},       32'(stall_busy),       32'(busy));
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_use_rs = 1'b0; ID_use_rt = 1'b0;
    ID_branch = 1'b0; ID_redirect = 1'b0;
    IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; IDEX_rd = 5'd0;
    EXMEM_MemRead = 1'b0; EXMEM_rd = 5'd0;
  endtask

  // Advance one clock; inputs change 1 ns after the edge, checks follow at +3 ns.
  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    nextCycle();
    settle();
    chkOut("rst.hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst.cycles", 32'(stall_cycles), 32'd0);

    // 1: lw $5 in EX, add using rs=$5 in ID -> one bubble, back to RUN
    Reset = 1'b0;
    IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_rd = 5'd5;
    ID_rs = 5'd5; ID_use_rs = 1'b1; ID_rt = 5'd9; ID_use_rt = 1'b1;
    settle();
    chkOut("lu.stall", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    idle(); ID_rs = 5'd5; ID_use_rs = 1'b1; EXMEM_MemRead = 1'b1; EXMEM_rd = 5'd5;
    settle();
    chkOut("lu.after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu.cycles", 32'(stall_cycles), 32'd1);

    // 2: lw $5 in EX, beq rs=$5 -> two bubbles, redirect ignored meanwhile
    nextCycle();
    idle();
    IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1; IDEX_rd = 5'd5;
    ID_branch = 1'b1; ID_rs = 5'd5; ID_use_rs = 1'b1; ID_redirect = 1'b1;
    settle();
    chkOut("brld.s1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; IDEX_rd = 5'd0;
    EXMEM_MemRead = 1'b1; EXMEM_rd = 5'd5;
    settle();
    chkOut("brld.s2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    nextCycle();
    EXMEM_MemRead = 1'b0; EXMEM_rd = 5'd0;
    settle();
    chkOut("brld.taken", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("brld.cycles", 32'(stall_cycles), 32'd3);
    chk("brld.satCycles", 32'(sStallCycles), 32'd3);

    // 3: add rd=$7 in EX, beq rt=$7 -> one bubble, then taken -> one flush
    nextCycle();
    idle();
    IDEX_RegWrite = 1'b1; IDEX_rd = 5'd7;
    ID_branch = 1'b1; ID_rt = 5'd7; ID_use_rt = 1'b1; ID_redirect = 1'b1;
    settle();
    chkOut("brex.stall", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    IDEX_RegWrite = 1'b0; IDEX_rd = 5'd0; EXMEM_rd = 5'd7;
    settle();
    chkOut("brex.taken", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    nextCycle();
    idle();
    settle();
    chkOut("brex.after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("brex.cycles", 32'(stall_cycles), 32'd4);
    chk("brex.satHold", 32'(sStallCycles), 32'd3);

    // 4: $0 destinations never stall; j in ID flushes
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd0; EXMEM_MemRead = 1'b1; EXMEM_rd = 5'd0;
    ID_branch = 1'b1; ID_rs = 5'd0; ID_use_rs = 1'b1; ID_redirect = 1'b1;
    settle();
    chkOut("zero.jump", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    nextCycle();
    idle();
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd5; ID_rs = 5'd5; ID_use_rs = 1'b0;
    ID_rt = 5'd6; ID_use_rt = 1'b1;
    settle();
    chkOut("unused.rs", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero.cycles", 32'(stall_cycles), 32'd4);

    // 6: three more load-use stalls; 2-bit copy stays at all-ones
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      idle();
      IDEX_MemRead = 1'b1; IDEX_rd = 5'd12; ID_rt = 5'd12; ID_use_rt = 1'b1;
      settle();
      chk("sat.bubble", 32'(ControlMuxsignal), 32'd1);
      nextCycle();
      idle();
      settle();
    end
    chk("sat.cycles", 32'(stall_cycles), 32'd7);
    chk("sat.satCycles", 32'(sStallCycles), 32'd3);

    // 5: reset during a two-cycle stall
    nextCycle();
    idle();
    IDEX_MemRead = 1'b1; IDEX_rd = 5'd3;
    ID_branch = 1'b1; ID_rs = 5'd3; ID_use_rs = 1'b1;
    settle();
    chkOut("rstmid.s1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    nextCycle();
    idle();
    EXMEM_MemRead = 1'b1; EXMEM_rd = 5'd3; ID_branch = 1'b1; ID_rs = 5'd3; ID_use_rs = 1'b1;
    Reset = 1'b1;
    settle();
    chkOut("rstmid.hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    nextCycle();
    Reset = 1'b0;
    idle();
    settle();
    chkOut("rstmid.after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rstmid.cycles", 32'(stall_cycles), 32'd0);
    chk("rstmid.satCycles", 32'(sStallCycles), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
